// File: rtl/clk_gen_ds_ctrl.sv
// Select/reset sequencer for the clock-generator/downsampler toplevel.
// Optional macro CLK_GEN_DS_CTRL_SKIP_SAME_EN: a request equal to the current select completes without a reset sequence.
module clk_gen_ds_ctrl #(
    parameter int unsigned reset_cycles_p  = 4,
    parameter int unsigned settle_cycles_p = 8,
    parameter logic [7:0]  init_select_p   = 8'h00
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req_v_i,
    input  logic [7:0] req_select_i,
    output logic       req_ready_o,
    output logic [7:0] select_o,
    output logic       clk_reset_o,
    output logic       ds_reset_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned MaxCycles = (reset_cycles_p > settle_cycles_p) ? reset_cycles_p : settle_cycles_p;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] ResetCnt  = CntW'(reset_cycles_p);
    localparam logic [CntW-1:0] SettleCnt = CntW'(settle_cycles_p);
    localparam logic [CntW-1:0] LastCnt   = CntW'(1);

    typedef enum logic [1:0] {
        HOLD,
        SETTLE,
        IDLE
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      select_q, select_d;
    logic            clkReset_q, clkReset_d;
    logic            dsReset_q, dsReset_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            startSeq;

    // Every output is computed one cycle ahead so that the ports come straight from flops.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        select_d   = select_q;
        clkReset_d = clkReset_q;
        dsReset_d  = dsReset_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        startSeq   = 1'b0;

        case (state_q)
            HOLD: begin
                if (cnt_q == LastCnt) begin
                    state_d    = SETTLE;
                    cnt_d      = SettleCnt;
                    clkReset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - LastCnt;
                end
            end
            SETTLE: begin
                if (cnt_q == LastCnt) begin
                    state_d   = IDLE;
                    dsReset_d = 1'b0;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - LastCnt;
                end
            end
            IDLE: begin
                if (req_v_i && ready_q) begin
`ifdef CLK_GEN_DS_CTRL_SKIP_SAME_EN
                    if (req_select_i == select_q) begin
                        done_d = 1'b1;
                    end else begin
                        startSeq = 1'b1;
                    end
`else
                    startSeq = 1'b1;
`endif
                end
            end
            default: begin
                startSeq = 1'b1;
            end
        endcase

        // The generator reset is raised together with the new select so the downsampler never sees a live clock on a stale tap.
        if (startSeq) begin
            state_d    = HOLD;
            cnt_d      = ResetCnt;
            clkReset_d = 1'b1;
            dsReset_d  = 1'b1;
            ready_d    = 1'b0;
            busy_d     = 1'b1;
            if (state_q == IDLE) begin
                select_d = req_select_i;
            end else begin
                select_d = init_select_p;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= HOLD;
            cnt_q      <= ResetCnt;
            select_q   <= init_select_p;
            clkReset_q <= 1'b1;
            dsReset_q  <= 1'b1;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            select_q   <= select_d;
            clkReset_q <= clkReset_d;
            dsReset_q  <= dsReset_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign req_ready_o = ready_q;
    assign select_o    = select_q;
    assign clk_reset_o = clkReset_q;
    assign ds_reset_o  = dsReset_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_clk_gen_ds_ctrl.sv
// Scoreboard bench for clk_gen_ds_ctrl: each queue entry holds one cycle of stimulus and the outputs expected in that cycle.
module tb_clk_gen_ds_ctrl;

    localparam int R = 4;
    localparam int S = 8;
    localparam logic [7:0] InitSel = 8'h00;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       req_v_i;
    logic [7:0] req_select_i;
    logic       req_ready_o;
    logic [7:0] select_o;
    logic       clk_reset_o;
    logic       ds_reset_o;
    logic       busy_o;
    logic       done_o;

    typedef struct {
        logic        rst;
        logic        v;
        logic [7:0]  sel;
        logic [12:0] exp;
    } entry_t;

    entry_t      sbq[$];
    entry_t      ent;
    logic [12:0] obs;
    int          total = 0;
    int          bad = 0;

    clk_gen_ds_ctrl #(
        .reset_cycles_p (R),
        .settle_cycles_p(S),
        .init_select_p  (InitSel)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_v_i     (req_v_i),
        .req_select_i(req_select_i),
        .req_ready_o (req_ready_o),
        .select_o    (select_o),
        .clk_reset_o (clk_reset_o),
        .ds_reset_o  (ds_reset_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected output vectors: {select, clk_reset, ds_reset, ready, busy, done}.
    function automatic logic [12:0] holdV(input logic [7:0] sel);
        return {sel, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    endfunction

    function automatic logic [12:0] settleV(input logic [7:0] sel);
        return {sel, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    endfunction

    function automatic logic [12:0] idleV(input logic [7:0] sel, input logic done);
        return {sel, 1'b0, 1'b0, 1'b1, 1'b0, done};
    endfunction

    task automatic pushEnt(input logic rst, input logic v, input logic [7:0] sel, input logic [12:0] exp);
        entry_t e;
        e.rst = rst;
        e.v   = v;
        e.sel = sel;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    // Expected HOLD/SETTLE/done trace of one complete sequence applying sel.
    task automatic pushSeq(input logic [7:0] sel);
        for (int i = 0; i < R; i++) pushEnt(1'b0, 1'b0, 8'h00, holdV(sel));
        for (int i = 0; i < S; i++) pushEnt(1'b0, 1'b0, 8'h00, settleV(sel));
        pushEnt(1'b0, 1'b0, 8'h00, idleV(sel, 1'b1));
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) pushEnt(1'b1, 1'b0, 8'h00, holdV(InitSel));
        pushSeq(InitSel);
        pushEnt(1'b0, 1'b0, 8'h00, idleV(InitSel, 1'b0));
        while (sbq.size() > 0) begin
            ent = sbq.pop_front();
            reset_i = ent.rst; req_v_i = ent.v; req_select_i = ent.sel;
            obs = {select_o, clk_reset_o, ds_reset_o, req_ready_o, busy_o, done_o};
            total++;
            if (obs !== ent.exp) begin
                bad++;
                $display("[TB] FAIL boot: got %h wanted %h at %0t", obs, ent.exp, $time);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_single;
        pushEnt(1'b0, 1'b1, 8'h35, idleV(InitSel, 1'b0));
        pushSeq(8'h35);
        pushEnt(1'b0, 1'b0, 8'h00, idleV(8'h35, 1'b0));
        while (sbq.size() > 0) begin
            ent = sbq.pop_front();
            reset_i = ent.rst; req_v_i = ent.v; req_select_i = ent.sel;
            obs = {select_o, clk_reset_o, ds_reset_o, req_ready_o, busy_o, done_o};
            total++;
            if (obs !== ent.exp) begin
                bad++;
                $display("[TB] FAIL single: got %h wanted %h at %0t", obs, ent.exp, $time);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_skip_same;
        pushEnt(1'b0, 1'b1, 8'h35, idleV(8'h35, 1'b0));
`ifdef CLK_GEN_DS_CTRL_SKIP_SAME_EN
        pushEnt(1'b0, 1'b0, 8'h00, idleV(8'h35, 1'b1));
`else
        pushSeq(8'h35);
`endif
        pushEnt(1'b0, 1'b0, 8'h00, idleV(8'h35, 1'b0));
        while (sbq.size() > 0) begin
            ent = sbq.pop_front();
            reset_i = ent.rst; req_v_i = ent.v; req_select_i = ent.sel;
            obs = {select_o, clk_reset_o, ds_reset_o, req_ready_o, busy_o, done_o};
            total++;
            if (obs !== ent.exp) begin
                bad++;
                $display("[TB] FAIL same_select: got %h wanted %h at %0t", obs, ent.exp, $time);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_ignored;
        pushEnt(1'b0, 1'b1, 8'h5A, idleV(8'h35, 1'b0));
        for (int i = 0; i < R; i++) pushEnt(1'b0, 1'b1, 8'hFF, holdV(8'h5A));
        for (int i = 0; i < S; i++) pushEnt(1'b0, (i % 2 == 0), 8'hFF, settleV(8'h5A));
        pushEnt(1'b0, 1'b0, 8'hFF, idleV(8'h5A, 1'b1));
        pushEnt(1'b0, 1'b0, 8'hFF, idleV(8'h5A, 1'b0));
        pushEnt(1'b0, 1'b0, 8'h00, idleV(8'h5A, 1'b0));
        while (sbq.size() > 0) begin
            ent = sbq.pop_front();
            reset_i = ent.rst; req_v_i = ent.v; req_select_i = ent.sel;
            obs = {select_o, clk_reset_o, ds_reset_o, req_ready_o, busy_o, done_o};
            total++;
            if (obs !== ent.exp) begin
                bad++;
                $display("[TB] FAIL ignored_req: got %h wanted %h at %0t", obs, ent.exp, $time);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_mid_reset;
        pushEnt(1'b0, 1'b1, 8'h35, idleV(8'h5A, 1'b0));
        for (int i = 0; i < R; i++) pushEnt(1'b0, 1'b0, 8'h00, holdV(8'h35));
        pushEnt(1'b0, 1'b0, 8'h00, settleV(8'h35));
        pushEnt(1'b1, 1'b1, 8'h77, settleV(8'h35));
        pushSeq(InitSel);
        pushEnt(1'b0, 1'b0, 8'h00, idleV(InitSel, 1'b0));
        while (sbq.size() > 0) begin
            ent = sbq.pop_front();
            reset_i = ent.rst; req_v_i = ent.v; req_select_i = ent.sel;
            obs = {select_o, clk_reset_o, ds_reset_o, req_ready_o, busy_o, done_o};
            total++;
            if (obs !== ent.exp) begin
                bad++;
                $display("[TB] FAIL mid_reset: got %h wanted %h at %0t", obs, ent.exp, $time);
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_back_to_back;
        pushEnt(1'b0, 1'b1, 8'h35, idleV(InitSel, 1'b0));
        for (int i = 0; i < R; i++) pushEnt(1'b0, 1'b1, 8'h07, holdV(8'h35));
        for (int i = 0; i < S; i++) pushEnt(1'b0, 1'b1, 8'h07, settleV(8'h35));
        pushEnt(1'b0, 1'b1, 8'h07, idleV(8'h35, 1'b1));
        pushSeq(8'h07);
        pushEnt(1'b0, 1'b0, 8'h00, idleV(8'h07, 1'b0));
        while (sbq.size() > 0) begin
            ent = sbq.pop_front();
            reset_i = ent.rst; req_v_i = ent.v; req_select_i = ent.sel;
            obs = {select_o, clk_reset_o, ds_reset_o, req_ready_o, busy_o, done_o};
            total++;
            if (obs !== ent.exp) begin
                bad++;
                $display("[TB] FAIL back_to_back: got %h wanted %h at %0t", obs, ent.exp, $time);
            end
            total++;
            if (ds_reset_o === 1'b0 && clk_reset_o !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_order: ds_reset=%b clk_reset=%b at %0t", ds_reset_o, clk_reset_o, $time);
            end
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        reset_i      = 1'b1;
        req_v_i      = 1'b0;
        req_select_i = 8'h00;
        @(posedge clk_i); #1;
        test_reset();
        test_single();
        test_skip_same();
        test_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
